// File: rtl/ace_mem_req_seq_pkg.sv
// Shared types and default constants for the ACE main-memory request sequencer.
// Optional timeout logic is enabled by defining ACE_MEM_TIMEOUT_EN.
package ace_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2
    } state_t;

    localparam int ACE_FIFO_DEPTH_DEF     = 4;
    localparam int ACE_TIMEOUT_CYCLES_DEF = 16;

endpackage

// File: rtl/ace_mem_req_seq_if.sv
// Memory request/response handshake between the sequencer (master) and memory (slave).
interface ace_mem_req_seq_if;

    logic mem_req_valid;
    logic mem_req_we;
    logic mem_req_ready;
    logic mem_rsp_valid;

    modport master (
        output mem_req_valid,
        output mem_req_we,
        input  mem_req_ready,
        input  mem_rsp_valid
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_we,
        output mem_req_ready,
        output mem_rsp_valid
    );

endinterface

// File: rtl/ace_mem_req_seq_fifo.sv
// Request queue holding one we bit per entry; accepts up to two pushes per cycle
// (din[0] lands first, din[1] second) and one pop.
module ace_req_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               push,
    input  logic [1:0]               din,
    input  logic                     pop,
    output logic                     dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem_q;
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_comb begin
        wptr_d  = wptr_q + AW'(push);
        rptr_d  = rptr_q + AW'(pop);
        count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push != 2'd0) mem_q[wptr_q] <= din[0];
        if (push == 2'd2) mem_q[wptr_q + AW'(1)] <= din[1];
    end

    assign dout  = mem_q[rptr_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign count = count_q;

endmodule

// File: rtl/ace_mem_req_seq.sv
// Serialises coherence-FSM memory strobes into single-outstanding memory requests.
// Define ACE_MEM_TIMEOUT_EN to abort WAIT_RSP after TIMEOUT_CYCLES.
module ace_mem_req_seq
    import ace_pkg::*;
#(
    parameter int FIFO_DEPTH     = ACE_FIFO_DEPTH_DEF,
    parameter int TIMEOUT_CYCLES = ACE_TIMEOUT_CYCLES_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          write_main_mem,
    input  logic                          read_main_mem,
    input  logic                          write_cache,
    input  logic                          read_cache,
    ace_mem_req_seq_if.master             mem,
    output logic                          cache_wr_en,
    output logic                          cache_rd_en,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   q_count,
    output logic                          overflow,
    output logic                          timeout_err
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t          state_q, state_d;
    logic            fifo_pop, fifo_empty, fifo_full, fifo_dout;
    logic [CW-1:0]   fifo_count, free_slots;
    logic            acc_wr, acc_rd, drop;
    logic [1:0]      push_cnt, push_din;
    logic            rsp_done, tmo_hit;
    logic            req_valid, req_we;
    logic            cache_wr_q, cache_rd_q, overflow_q;

    // Admission: free space includes a slot released by a same-cycle pop;
    // the write is offered first so it wins a single remaining slot.
    always_comb begin
        free_slots = CW'(FIFO_DEPTH) - fifo_count + CW'(fifo_pop);
        acc_wr     = write_main_mem && (!fifo_full || fifo_pop);
        acc_rd     = read_main_mem && (free_slots > CW'(acc_wr));
        push_cnt   = {1'b0, acc_wr} + {1'b0, acc_rd};
        push_din   = {1'b0, acc_wr};
        drop       = (write_main_mem && !acc_wr) || (read_main_mem && !acc_rd);
    end

    ace_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_cnt),
        .din   (push_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef ACE_MEM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_q, tmo_d;
    logic          tmo_err_q;

    // Counter is held at zero outside WAIT_RSP, so every entry starts from zero.
    always_comb begin
        tmo_d   = (state_q == WAIT_RSP) ? tmo_q + TW'(1) : '0;
        tmo_hit = (state_q == WAIT_RSP) && !mem.mem_rsp_valid &&
                  (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q     <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_q     <= tmo_d;
            tmo_err_q <= tmo_err_q | tmo_hit;
        end
    end

    assign timeout_err = tmo_err_q;
`else
    logic unused_tmo_cfg;

    assign unused_tmo_cfg = (TIMEOUT_CYCLES > 0);
    assign tmo_hit        = 1'b0;
    assign timeout_err    = 1'b0;
`endif

    assign rsp_done = (state_q == WAIT_RSP) && (mem.mem_rsp_valid || tmo_hit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (!fifo_empty)         state_d = ISSUE;
            ISSUE:    if (mem.mem_req_ready)   state_d = WAIT_RSP;
            WAIT_RSP: if (rsp_done)            state_d = fifo_empty ? IDLE : ISSUE;
            default:                           state_d = IDLE;
        endcase
    end

    // Head entry is not popped until acceptance, so we stays stable under backpressure.
    always_comb begin
        req_valid = 1'b0;
        req_we    = 1'b0;
        fifo_pop  = 1'b0;
        if (state_q == ISSUE) begin
            req_valid = 1'b1;
            req_we    = fifo_dout;
            fifo_pop  = mem.mem_req_ready;
        end
    end

    assign mem.mem_req_valid = req_valid;
    assign mem.mem_req_we    = req_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cache_wr_q <= 1'b0;
            cache_rd_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            cache_wr_q <= write_cache;
            cache_rd_q <= read_cache;
            overflow_q <= overflow_q | drop;
        end
    end

    assign cache_wr_en = cache_wr_q;
    assign cache_rd_en = cache_rd_q;
    assign overflow    = overflow_q;
    assign q_count     = fifo_count;
    assign busy        = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_ace_mem_req_seq.sv
// Directed bench for ace_mem_req_seq with FIFO_DEPTH=4, TIMEOUT_CYCLES=16.
module tb_ace_mem_req_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       write_main_mem = 1'b0;
    logic       read_main_mem  = 1'b0;
    logic       write_cache    = 1'b0;
    logic       read_cache     = 1'b0;
    logic       cache_wr_en, cache_rd_en, busy, overflow, timeout_err;
    logic [2:0] q_count;

    int n_tests = 0;
    int n_fail  = 0;

    ace_mem_req_seq_if mem_if ();

    ace_mem_req_seq #(
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .write_main_mem (write_main_mem),
        .read_main_mem  (read_main_mem),
        .write_cache    (write_cache),
        .read_cache     (read_cache),
        .mem            (mem_if.master),
        .cache_wr_en    (cache_wr_en),
        .cache_rd_en    (cache_rd_en),
        .busy           (busy),
        .q_count        (q_count),
        .overflow       (overflow),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 32'(mem_if.mem_req_valid), 0);
        chk({tag, "_we"},    32'(mem_if.mem_req_we), 0);
        chk({tag, "_busy"},  32'(busy), 0);
        chk({tag, "_qcnt"},  32'(q_count), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_we [4];
        mem_if.mem_req_ready = 1'b0;
        mem_if.mem_rsp_valid = 1'b0;

        // Reset values
        step(); step();
        chk_idle("rst");
        chk("rst_cwr",  32'(cache_wr_en), 0);
        chk("rst_crd",  32'(cache_rd_en), 0);
        chk("rst_ovf",  32'(overflow), 0);
        chk("rst_tmo",  32'(timeout_err), 0);
        rst = 1'b0;

        // Cache strobes pass through one cycle later, unqueued
        write_cache = 1'b1;
        step();
        write_cache = 1'b0; read_cache = 1'b1;
        chk("cwr_en",   32'(cache_wr_en), 1);
        chk("cwr_rd",   32'(cache_rd_en), 0);
        chk("cwr_busy", 32'(busy), 0);
        step();
        read_cache = 1'b0;
        chk("crd_wr",   32'(cache_wr_en), 0);
        chk("crd_en",   32'(cache_rd_en), 1);
        step();
        chk("crd_off",  32'(cache_rd_en), 0);

        // Single write
        mem_if.mem_req_ready = 1'b1;
        write_main_mem = 1'b1;
        step();
        write_main_mem = 1'b0;
        chk("sw_q1",    32'(q_count), 1);
        chk("sw_v0",    32'(mem_if.mem_req_valid), 0);
        chk("sw_busy",  32'(busy), 1);
        step();
        chk("sw_valid", 32'(mem_if.mem_req_valid), 1);
        chk("sw_we",    32'(mem_if.mem_req_we), 1);
        step();
        chk("sw_pop",   32'(q_count), 0);
        chk("sw_wait",  32'(mem_if.mem_req_valid), 0);
        chk("sw_wbusy", 32'(busy), 1);
        step();
        mem_if.mem_rsp_valid = 1'b1;
        step();
        mem_if.mem_rsp_valid = 1'b0;
        chk_idle("sw_done");

        // Simultaneous strobes: write then read
        write_main_mem = 1'b1; read_main_mem = 1'b1;
        step();
        write_main_mem = 1'b0; read_main_mem = 1'b0;
        chk("sim_q2",   32'(q_count), 2);
        step();
        chk("sim_v1",   32'(mem_if.mem_req_valid), 1);
        chk("sim_we1",  32'(mem_if.mem_req_we), 1);
        step();
        chk("sim_q1",   32'(q_count), 1);
        mem_if.mem_rsp_valid = 1'b1;
        step();
        mem_if.mem_rsp_valid = 1'b0;
        chk("sim_v2",   32'(mem_if.mem_req_valid), 1);
        chk("sim_we2",  32'(mem_if.mem_req_we), 0);
        step();
        chk("sim_q0",   32'(q_count), 0);
        mem_if.mem_rsp_valid = 1'b1;
        step();
        mem_if.mem_rsp_valid = 1'b0;
        chk_idle("sim_done");

        // Backpressure: request held stable, no pop
        mem_if.mem_req_ready = 1'b0;
        write_main_mem = 1'b1;
        step();
        write_main_mem = 1'b0;
        step();
        for (int i = 0; i < 6; i++) begin
            chk("bp_valid", 32'(mem_if.mem_req_valid), 1);
            chk("bp_we",    32'(mem_if.mem_req_we), 1);
            chk("bp_qcnt",  32'(q_count), 1);
            step();
        end
        mem_if.mem_req_ready = 1'b1;
        step();
        chk("bp_pop",   32'(q_count), 0);
        chk("bp_wait",  32'(mem_if.mem_req_valid), 0);
        mem_if.mem_rsp_valid = 1'b1;
        step();
        mem_if.mem_rsp_valid = 1'b0;
        chk_idle("bp_done");

        // Overflow: 5 reads into depth 4 while stalled
        mem_if.mem_req_ready = 1'b0;
        read_main_mem = 1'b1;
        for (int i = 0; i < 5; i++) step();
        read_main_mem = 1'b0;
        chk("ov_qcnt",  32'(q_count), 4);
        chk("ov_flag",  32'(overflow), 1);
        mem_if.mem_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("ov_valid", 32'(mem_if.mem_req_valid), 1);
            chk("ov_we",    32'(mem_if.mem_req_we), 0);
            step();
            chk("ov_qdec",  32'(q_count), 32'(3 - i));
            mem_if.mem_rsp_valid = 1'b1;
            step();
            mem_if.mem_rsp_valid = 1'b0;
        end
        chk_idle("ov_done");
        chk("ov_sticky", 32'(overflow), 1);

        // Reset clears sticky overflow
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("ov_clr",   32'(overflow), 0);

        // One slot free with both strobes: write survives, read dropped
        mem_if.mem_req_ready = 1'b0;
        read_main_mem = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("sv_q3",    32'(q_count), 3);
        chk("sv_noov",  32'(overflow), 0);
        write_main_mem = 1'b1;
        step();
        write_main_mem = 1'b0; read_main_mem = 1'b0;
        chk("sv_q4",    32'(q_count), 4);
        chk("sv_ovf",   32'(overflow), 1);
        exp_we[0] = 1'b0; exp_we[1] = 1'b0; exp_we[2] = 1'b0; exp_we[3] = 1'b1;
        mem_if.mem_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("sv_valid", 32'(mem_if.mem_req_valid), 1);
            chk("sv_we",    32'(mem_if.mem_req_we), 32'(exp_we[i]));
            step();
            mem_if.mem_rsp_valid = 1'b1;
            step();
            mem_if.mem_rsp_valid = 1'b0;
        end
        chk_idle("sv_done");

        // Missing response: timeout with macro, indefinite wait without
        write_main_mem = 1'b1; read_main_mem = 1'b1;
        step();
        write_main_mem = 1'b0; read_main_mem = 1'b0;
        step();
        step();
        chk("to_q1",    32'(q_count), 1);
`ifdef ACE_MEM_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            step();
            chk("to_wait", 32'(mem_if.mem_req_valid), 0);
            chk("to_err0", 32'(timeout_err), 0);
        end
        step();
        chk("to_err1",  32'(timeout_err), 1);
        chk("to_next",  32'(mem_if.mem_req_valid), 1);
        chk("to_we",    32'(mem_if.mem_req_we), 0);
`else
        for (int i = 0; i < 20; i++) step();
        chk("nt_wait",  32'(mem_if.mem_req_valid), 0);
        chk("nt_busy",  32'(busy), 1);
        chk("nt_err",   32'(timeout_err), 0);
        mem_if.mem_rsp_valid = 1'b1;
        step();
        mem_if.mem_rsp_valid = 1'b0;
        chk("nt_next",  32'(mem_if.mem_req_valid), 1);
        chk("nt_we",    32'(mem_if.mem_req_we), 0);
`endif
        step();
        mem_if.mem_rsp_valid = 1'b1;
        step();
        mem_if.mem_rsp_valid = 1'b0;
        chk_idle("to_done");

        // Reset during WAIT_RSP with another entry queued
        write_main_mem = 1'b1; read_main_mem = 1'b1;
        step();
        write_main_mem = 1'b0; read_main_mem = 1'b0;
        step();
        step();
        chk("rw_q1",    32'(q_count), 1);
        chk("rw_busy",  32'(busy), 1);
        rst = 1'b1;
        #1;
        chk_idle("rw_async");
        step();
        rst = 1'b0;
        mem_if.mem_rsp_valid = 1'b1;
        step();
        mem_if.mem_rsp_valid = 1'b0;
        chk_idle("rw_late");
        step(); step();
        chk_idle("rw_noreplay");
        chk("rw_ovf",   32'(overflow), 0);
        chk("rw_tmo",   32'(timeout_err), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ace_mem_req_seq.md
ACE_MEM_REQ_SEQ -- requirements
Module: ace_mem_req_seq

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, main-memory request queue depth (power of 2, >=2).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum WAIT_RSP cycles before abort.
REQ-003 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port write_main_mem  input  1  one-cycle strobe from the coherence FSM: writeback to memory.
REQ-006 SHALL have port read_main_mem  input  1  one-cycle strobe from the coherence FSM: line fill from memory.
REQ-007 SHALL have ports write_cache and read_cache  input  1 each  one-cycle strobes from the coherence FSM: local cache access.
REQ-008 SHALL have port mem_req_valid  output  1  memory request valid.
REQ-009 SHALL have port mem_req_we  output  1  1 = write, 0 = read; stable while mem_req_valid.
REQ-010 SHALL have port mem_req_ready  input  1  memory accepts request.
REQ-011 SHALL have port mem_rsp_valid  input  1  memory completion pulse.
REQ-012 SHALL have ports cache_wr_en and cache_rd_en  output  1 each  cache access pulses.
REQ-013 SHALL have port busy  output  1  queue non-empty or state != IDLE.
REQ-014 SHALL have port q_count  output  $clog2(FIFO_DEPTH)+1  queued entries.
REQ-015 SHALL have port overflow  output  1  sticky: a main-memory strobe was dropped.
REQ-016 SHALL have port timeout_err  output  1  sticky: request aborted on timeout (tied 0 without ACE_MEM_TIMEOUT_EN).

Function
REQ-017 SHALL register cache_wr_en/cache_rd_en exactly one cycle after write_cache/read_cache, unqueued.
REQ-018 SHALL enqueue each main-memory strobe into the FIFO (entry = 1-bit we) in the cycle it is sampled.
REQ-019 SHALL, when write_main_mem and read_main_mem arrive together, enqueue the write first, then the read.
REQ-020 SHALL, on a full FIFO (with space counted after a same-cycle pop), drop excess strobes and set overflow; the write survives if only one slot is free.
REQ-021 SHALL run FSM IDLE -> ISSUE when the FIFO is non-empty; ISSUE holds mem_req_valid=1, mem_req_we=head.we.
REQ-022 SHALL pop the head and move ISSUE -> WAIT_RSP on the cycle mem_req_valid && mem_req_ready.
REQ-023 SHALL move WAIT_RSP -> ISSUE if the FIFO is non-empty, else -> IDLE, on mem_rsp_valid; one outstanding request maximum.
REQ-024 SHALL ignore mem_rsp_valid outside WAIT_RSP.
REQ-025 SHALL keep q_count equal to pushes minus pops, never exceeding FIFO_DEPTH, with pointers wrapping modulo FIFO_DEPTH.

Reset
REQ-026 SHALL on rst: state=IDLE, FIFO empty, q_count=0, mem_req_valid=0, mem_req_we=0, cache_wr_en=0, cache_rd_en=0, busy=0, overflow=0, timeout_err=0, timeout counter=0.
REQ-027 SHALL abandon any in-flight request when rst asserts mid-operation, with no replay after release.

Configuration
REQ-028 SHALL with ACE_MEM_TIMEOUT_EN defined count WAIT_RSP cycles; at TIMEOUT_CYCLES without mem_rsp_valid, set timeout_err and leave WAIT_RSP as if a response arrived; counter clears on WAIT_RSP entry.
REQ-029 SHALL without ACE_MEM_TIMEOUT_EN wait indefinitely in WAIT_RSP, with no counter logic and timeout_err constant 0.

Structure
REQ-030 SHALL place the state enum (IDLE/ISSUE/WAIT_RSP) and default parameter constants in shared package ace_pkg.
REQ-031 SHALL implement the queue as sub-module ace_req_fifo (push, pop, din, dout, full, empty, count).

Verification
REQ-032 SHALL cover single write: write_main_mem pulse, mem_req_ready=1 -> mem_req_valid 1 cycle later with we=1, mem_rsp_valid 3 cycles later -> IDLE, busy=0.
REQ-033 SHALL cover simultaneous strobes: write_main_mem=read_main_mem=1 in one cycle -> two requests issued in order we=1 then we=0.
REQ-034 SHALL cover overflow: mem_req_ready=0 and 5 read strobes with FIFO_DEPTH=4 -> q_count=4, overflow=1, first 4 served after ready rises.
REQ-035 SHALL cover backpressure: mem_req_ready=0 for 6 cycles -> mem_req_valid and mem_req_we held stable, no pop.
REQ-036 SHALL cover timeout (macro on): no mem_rsp_valid for 16 cycles -> timeout_err=1, next queued request issued.
REQ-037 SHALL cover reset in WAIT_RSP: rst pulse -> all outputs at reset values, a late mem_rsp_valid is ignored.
